// File: rtl/bus_decoder.sv
// Single-master, NSLV-slave address decoder with one outstanding request.
// Requests are routed by a priority address map and rebased. Responses are registered; unmapped or timed-out accesses return an error.
module bus_decoder #(
    parameter int NSLV = 4,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h8000_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0] SLV_TOP  = {32'h8010_0000, 32'h0200_C000, 32'h0100_1000, 32'h0001_0000},
    parameter int TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               memory_valid,
    input  logic               memory_instr,
    input  logic [AW-1:0]      memory_addr,
    input  logic [DW-1:0]      memory_wdata,
    input  logic [DW/8-1:0]    memory_wstrb,
    output logic [DW-1:0]      memory_rdata,
    output logic               memory_error,
    output logic               memory_ready,
    output logic [NSLV-1:0]    slv_valid,
    output logic               slv_instr,
    output logic [AW-1:0]      slv_addr,
    output logic [DW-1:0]      slv_wdata,
    output logic [DW/8-1:0]    slv_wstrb,
    input  logic [NSLV*DW-1:0] slv_rdata,
    input  logic [NSLV-1:0]    slv_ready,
    output logic               busy
);

    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   sel, sel_n;
    logic [CW-1:0]   count, count_n;
    logic            ready_n, error_n;
    logic [DW-1:0]   rdata_n;

    logic            hit;
    logic [IW-1:0]   hit_idx;
    logic [AW-1:0]   hit_base;
    logic [NSLV-1:0] hit_vec;
    logic            sel_ready;
    logic [DW-1:0]   sel_rdata;

    // Lowest index wins overlapping windows; a slot with TOP<=BASE never matches.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_base = '0;
        hit_vec  = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (!hit && memory_addr >= SLV_BASE[i*AW +: AW] && memory_addr < SLV_TOP[i*AW +: AW]) begin
                hit        = 1'b1;
                hit_idx    = IW'(i);
                hit_base   = SLV_BASE[i*AW +: AW];
                hit_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel == IW'(i)) begin
                sel_ready = slv_ready[i];
                sel_rdata = slv_rdata[i*DW +: DW];
            end
        end
    end

    assign slv_addr  = memory_addr - hit_base;
    assign slv_instr = memory_instr;
    assign slv_wdata = memory_wdata;
    assign slv_wstrb = memory_wstrb;
    assign busy      = (state == ST_WAIT);

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        count_n   = count;
        ready_n   = 1'b0;
        error_n   = 1'b0;
        rdata_n   = memory_rdata;
        slv_valid = '0;
        case (state)
            ST_IDLE: begin
                if (memory_valid) begin
                    if (hit) begin
                        slv_valid = hit_vec;
                        sel_n     = hit_idx;
                        count_n   = '0;
                        state_n   = ST_WAIT;
                    end else begin
                        ready_n = 1'b1;
                        error_n = 1'b1;
                        rdata_n = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (sel_ready) begin
                    ready_n = 1'b1;
                    rdata_n = sel_rdata;
                    state_n = ST_IDLE;
                end else if (TIMEOUT != 0 && count == LAST) begin
                    ready_n = 1'b1;
                    error_n = 1'b1;
                    rdata_n = '0;
                    state_n = ST_IDLE;
                end else if (count != '1) begin
                    count_n = count + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            sel          <= '0;
            count        <= '0;
            memory_ready <= 1'b0;
            memory_error <= 1'b0;
            memory_rdata <= '0;
        end else begin
            state        <= state_n;
            sel          <= sel_n;
            count        <= count_n;
            memory_ready <= ready_n;
            memory_error <= error_n;
            memory_rdata <= rdata_n;
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: directed scenarios plus randomized transactions
// checked against an address-map reference model with timeout and noise injection.
module tb_bus_decoder;

    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          memory_valid;
    logic          memory_instr;
    logic [31:0]   memory_addr;
    logic [31:0]   memory_wdata;
    logic [3:0]    memory_wstrb;
    logic [31:0]   memory_rdata;
    logic          memory_error;
    logic          memory_ready;
    logic [4:0]    slv_valid;
    logic          slv_instr;
    logic [31:0]   slv_addr;
    logic [31:0]   slv_wdata;
    logic [3:0]    slv_wstrb;
    logic [159:0]  slv_rdata;
    logic [4:0]    slv_ready;
    logic          busy;

    // Slot 4 fully overlaps the bottom of slot 0, so it must never be selected.
    bus_decoder #(
        .NSLV(5),
        .AW(32),
        .DW(32),
        .SLV_BASE({32'h0000_0000, 32'h8000_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000}),
        .SLV_TOP ({32'h0000_0200, 32'h8010_0000, 32'h0200_C000, 32'h0100_1000, 32'h0001_0000}),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .memory_valid(memory_valid),
        .memory_instr(memory_instr),
        .memory_addr(memory_addr),
        .memory_wdata(memory_wdata),
        .memory_wstrb(memory_wstrb),
        .memory_rdata(memory_rdata),
        .memory_error(memory_error),
        .memory_ready(memory_ready),
        .slv_valid(slv_valid),
        .slv_instr(slv_instr),
        .slv_addr(slv_addr),
        .slv_wdata(slv_wdata),
        .slv_wstrb(slv_wstrb),
        .slv_rdata(slv_rdata),
        .slv_ready(slv_ready),
        .busy(busy)
    );

    always #5 clock = ~clock;

    logic [31:0] base_m [5] = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] top_m  [5] = '{32'h0001_0000, 32'h0100_1000, 32'h0200_C000, 32'h8010_0000, 32'h0000_0200};

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 5; i++)
            if (a >= base_m[i] && a < top_m[i]) return i;
        return -1;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where the response is visible.
    task automatic transact(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                            input logic ins, input int k, input logic [31:0] rd, input bit noise);
        int idx;
        int c;
        bit done;
        logic [4:0] ev;
        logic [31:0] ea;
        idx = decode(addr);
        ev = '0;
        ea = addr;
        if (idx >= 0) begin
            ev[idx] = 1'b1;
            ea = addr - base_m[idx];
        end
        memory_valid = 1'b1;
        memory_addr  = addr;
        memory_wdata = wd;
        memory_wstrb = ws;
        memory_instr = ins;
        slv_ready    = '0;
        #1;
        check("slv_valid_req", slv_valid, ev);
        check("slv_addr", slv_addr, ea);
        check("slv_wdata", slv_wdata, wd);
        check("slv_wstrb", slv_wstrb, ws);
        check("slv_instr", slv_instr, ins);
        check("busy_req", busy, 1'b0);
        if (idx < 0) begin
            @(negedge clock);
            memory_valid = 1'b0;
            check("unmapped_ready", memory_ready, 1'b1);
            check("unmapped_error", memory_error, 1'b1);
            check("unmapped_rdata", memory_rdata, 32'h0);
            last_rd = '0;
            return;
        end
        done = 1'b0;
        c = 1;
        while (!done && c <= TO) begin
            @(negedge clock);
            memory_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            slv_ready    = noise ? 5'($urandom) : 5'b0;
            slv_ready[idx] = 1'b0;
            slv_rdata    = {$urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            check("wait_slv_valid", slv_valid, 5'b0);
            check("wait_busy", busy, 1'b1);
            check("wait_ready", memory_ready, 1'b0);
            check("wait_rdata_hold", memory_rdata, last_rd);
            if (c == k) begin
                slv_ready[idx] = 1'b1;
                slv_rdata[idx*32 +: 32] = rd;
                done = 1'b1;
            end
            c++;
        end
        @(negedge clock);
        memory_valid = 1'b0;
        slv_ready    = '0;
        check("resp_ready", memory_ready, 1'b1);
        check("resp_error", memory_error, !done);
        check("resp_rdata", memory_rdata, done ? rd : 32'h0);
        check("resp_busy", busy, 1'b0);
        last_rd = done ? rd : 32'h0;
    endtask

    // Two idle cycles with stray slave readies that must not produce a response.
    task automatic idle_gap();
        @(negedge clock);
        memory_valid = 1'b0;
        slv_ready = 5'($urandom);
        slv_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        slv_ready = '0;
        check("idle_no_ready", memory_ready, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int r;
        reset = 1'b0;
        memory_valid = 1'b0;
        memory_instr = 1'b0;
        memory_addr  = '0;
        memory_wdata = '0;
        memory_wstrb = '0;
        slv_rdata    = '0;
        slv_ready    = '0;
        #2;
        check("rst_ready", memory_ready, 1'b0);
        check("rst_error", memory_error, 1'b0);
        check("rst_rdata", memory_rdata, 32'h0);
        check("rst_busy", busy, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        transact(32'h8000_0004, 32'h0, 4'h0, 1'b0, 3, 32'hDEAD_BEEF, 1'b0);
        idle_gap();
        transact(32'h0100_0010, 32'h41, 4'hF, 1'b0, 2, 32'h1234_5678, 1'b0);
        idle_gap();
        transact(32'h4000_0000, 32'h0, 4'h0, 1'b1, 1, 32'h0, 1'b0);
        transact(32'h0200_0100, 32'h0, 4'h0, 1'b1, 1, 32'hCAFE_0001, 1'b0);
        transact(32'h0200_0200, 32'h0, 4'h0, 1'b0, TO + 1, 32'h0, 1'b0);
        transact(32'h0200_0300, 32'h0, 4'h0, 1'b0, TO, 32'hA5A5_5A5A, 1'b0);
        transact(32'h8000_0020, 32'h0, 4'h0, 1'b0, 4, 32'h0BAD_F00D, 1'b1);
        transact(32'h0000_0100, 32'h0, 4'h0, 1'b0, 1, 32'h0000_0100, 1'b0);
        transact(32'h0100_0FFF, 32'h77, 4'h3, 1'b0, 1, 32'h0000_0FFF, 1'b0);
        transact(32'h0100_1000, 32'h0, 4'h0, 1'b0, 1, 32'h0, 1'b0);
        transact(32'h8010_0000, 32'h0, 4'h0, 1'b0, 1, 32'h0, 1'b0);
        transact(32'hFFFF_FFFF, 32'h0, 4'h0, 1'b0, 1, 32'h0, 1'b0);
        transact(32'h0000_FFFF, 32'h0, 4'h0, 1'b0, 5, 32'h5555_AAAA, 1'b1);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            if (r < 4) a = base_m[r] + ($urandom % (top_m[r] - base_m[r]));
            else a = $urandom;
            if ($urandom_range(0, 1) == 1) idle_gap();
            transact(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(1, TO + 1), $urandom, 1'($urandom));
        end

        // Reset in the middle of a wait: no response may ever appear for it.
        idle_gap();
        memory_valid = 1'b1;
        memory_addr  = 32'h8000_0010;
        memory_wstrb = 4'h0;
        @(negedge clock);
        memory_valid = 1'b0;
        @(negedge clock);
        check("pre_rst_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ready", memory_ready, 1'b0);
        check("midrst_error", memory_error, 1'b0);
        check("midrst_rdata", memory_rdata, 32'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_slv_valid", slv_valid, 5'b0);
        @(negedge clock);
        reset = 1'b1;
        slv_ready = 5'b01000;
        slv_rdata[3*32 +: 32] = 32'h1111_2222;
        @(negedge clock);
        slv_ready = '0;
        check("late_ready_dropped", memory_ready, 1'b0);
        check("late_busy", busy, 1'b0);
        last_rd = '0;
        @(negedge clock);
        transact(32'h0200_0040, 32'h0, 4'h0, 1'b0, 2, 32'h600D_600D, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
